// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy engine: one read cycle and one write cycle per word, ascending order.
// Define COPY_CHECKSUM_EN to enable the running checksum of copied words; otherwise checksum is 0.
module mem_copy_engine #(
    parameter int LEN_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] length,
    output logic             busy,
    output logic             done,
    output logic [31:0]      checksum,
    output logic [31:0]      mem_addr,
    output logic             mem_read,
    output logic             mem_write_enable,
    output logic [31:0]      mem_write_data,
    input  logic [31:0]      mem_read_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [31:0]      buf_q, buf_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] idx_inc_s;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept_s;
    logic             last_word_s;
    logic             write_s;

    assign idx_inc_s   = idx_q + {{(LEN_W-1){1'b0}}, 1'b1};
    assign last_word_s = (idx_inc_s == len_q);
    assign accept_s    = (state_q == IDLE) && start;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != {LEN_W{1'b0}}) begin
                        state_d = READ;
                    end else begin
                        state_d = FINISH;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            READ:   state_d = WRITE;
            WRITE: begin
                if (last_word_s) begin
                    state_d = FINISH;
                end else begin
                    state_d = READ;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory-side outputs decoded from the current state
    always_comb begin
        mem_addr       = 32'h0000_0000;
        mem_read       = 1'b0;
        write_s        = 1'b0;
        mem_write_data = 32'h0000_0000;
        case (state_q)
            READ: begin
                mem_addr = src_q + 32'(idx_q);
                mem_read = 1'b1;
            end
            WRITE: begin
                mem_addr       = dst_q + 32'(idx_q);
                write_s        = 1'b1;
                mem_write_data = buf_q;
            end
            default: begin
                mem_addr = 32'h0000_0000;
            end
        endcase
    end

    // Reset must block a write even in the middle of a WRITE cycle
    assign mem_write_enable = write_s & rst_n;

    // Datapath next-state: latch request, capture read data, advance word index
    always_comb begin
        src_d = src_q;
        dst_d = dst_q;
        len_d = len_q;
        idx_d = idx_q;
        buf_d = buf_q;
        if (accept_s) begin
            src_d = src_addr;
            dst_d = dst_addr;
            len_d = length;
            idx_d = {LEN_W{1'b0}};
        end else if (state_q == READ) begin
            buf_d = mem_read_data;
        end else if (state_q == WRITE) begin
            idx_d = idx_inc_s;
        end else begin
            idx_d = idx_q;
        end
    end

    // Status outputs are registered from the next state
    always_comb begin
        busy_d = (state_d == READ) || (state_d == WRITE);
        done_d = (state_d == FINISH);
    end

    // Datapath and status registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_q  <= 32'h0000_0000;
            dst_q  <= 32'h0000_0000;
            len_q  <= {LEN_W{1'b0}};
            idx_q  <= {LEN_W{1'b0}};
            buf_q  <= 32'h0000_0000;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            src_q  <= src_d;
            dst_q  <= dst_d;
            len_q  <= len_d;
            idx_q  <= idx_d;
            buf_q  <= buf_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

`ifdef COPY_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;

    // Checksum restarts on each accepted request and accumulates every captured word
    always_comb begin
        sum_d = sum_q;
        if (accept_s) begin
            sum_d = 32'h0000_0000;
        end else if (state_q == READ) begin
            sum_d = sum_q + mem_read_data;
        end else begin
            sum_d = sum_q;
        end
    end

    // Checksum register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= 32'h0000_0000;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 32'h0000_0000;
`endif

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL have parameter LEN_W, default 11, width of the length input (max transfer 2^LEN_W-1 words).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-005 SHALL have port src_addr  input  32  first source word address; sampled with start.
REQ-006 SHALL have port dst_addr  input  32  first destination word address; sampled with start.
REQ-007 SHALL have port length  input  LEN_W  number of words to copy; sampled with start.
REQ-008 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port checksum  output  32  running sum of copied words (see Configuration).
REQ-011 SHALL have port mem_addr  output  32  word address to data memory.
REQ-012 SHALL have port mem_read  output  1  read strobe to data memory.
REQ-013 SHALL have port mem_write_enable  output  1  write strobe; memory commits on the negedge of the same cycle.
REQ-014 SHALL have port mem_write_data  output  32  write data to data memory.
REQ-015 SHALL have port mem_read_data  input  32  combinational read data for mem_addr.

Function
REQ-016 SHALL implement states IDLE, READ, WRITE, FINISH.
REQ-017 IDLE: on start=1 with length!=0, latch src, dst and length, clear the word index, go to READ; with length=0, go to FINISH with no memory access.
REQ-018 READ: mem_addr=src+idx, mem_read=1, mem_write_enable=0; at posedge, capture mem_read_data into the data buffer, go to WRITE.
REQ-019 WRITE: mem_addr=dst+idx, mem_write_enable=1, mem_read=0, mem_write_data=buffer; at posedge, idx+1; if idx+1==length go to FINISH, else go to READ.
REQ-020 FINISH: done=1 for exactly one cycle, busy=0, go to IDLE.
REQ-021 Throughput SHALL be exactly 2 cycles per word; done SHALL assert 2*length+1 cycles after the start-sampling edge (1 cycle for length=0).
REQ-022 Address arithmetic SHALL be modulo 2^32; wrap-around past 32'hFFFFFFFF is legal and not flagged.
REQ-023 Copy order SHALL be strictly ascending; with overlapping ranges and dst>src, already-written words are re-read (defined, not corrected).
REQ-024 start SHALL be ignored while state != IDLE; no queuing.
REQ-025 In IDLE and FINISH, mem_read=0, mem_write_enable=0, mem_addr=0 and mem_write_data=0.
REQ-026 mem_read and mem_write_enable SHALL never be high in the same cycle.

Reset
REQ-027 On a posedge with rst_n=0: state=IDLE, idx=0, buffer=0, checksum=0, busy=0, done=0.
REQ-028 mem_write_enable SHALL be combinationally gated by rst_n, so no memory write occurs in any cycle where rst_n=0, including mid-transfer.
REQ-029 A reset mid-copy SHALL abandon the transfer without a done pulse; words already written remain written.

Configuration
REQ-030 Macro COPY_CHECKSUM_EN: when defined, checksum SHALL be cleared on accepted start and SHALL add each captured word (mod 2^32) in READ; it holds its value after done until the next start.
REQ-031 Without COPY_CHECKSUM_EN, checksum SHALL be tied to 32'h0 and no adder SHALL be instantiated; all other behaviour is identical.

Verification
REQ-032 Preload mem[0..4]={5,10,1,20,25}; start with src=0, dst=500, length=5 -> mem[500..504]={5,10,1,20,25}, done at cycle 11, checksum=61 (with the macro) or 0 (without).
REQ-033 start with length=0 -> done one cycle later; no mem_read or mem_write_enable activity; busy never asserts.
REQ-034 Pulse start again at cycle 3 of a 5-word copy with different addresses -> ignored; first copy completes unchanged and only one done pulse occurs.
REQ-035 Drop rst_n in the WRITE state of word 2 of a 5-word copy to dst=600 -> mem[600..601] written, mem[602..604] unchanged, no done, state IDLE, checksum=0.
REQ-036 Preload mem[1000..1004]={5,10,1,20,25}; overlapping copy src=1000, dst=1001, length=4 -> mem[1001..1004]={5,5,5,5}.
REQ-037 Copy with src=32'hFFFFFFFE, length=3 -> mem_addr sequence wraps FFFFFFFE, FFFFFFFF, 00000000 in the READ states.
